// File: rtl/gcl_execute_sm.sv
// Gate-control-list sequencer: walks a double-banked list of {gates, interval} entries on each
// cycle start, with admin/oper bank swaps taken only at cycle boundaries.
module gcl_execute_sm #(
  parameter int unsigned NUM_QUEUES    = 8,
  parameter int unsigned GCL_DEPTH     = 16,
  parameter int unsigned TI_WIDTH      = 32,
  parameter int unsigned CLK_PERIOD_NS = 8,
  localparam int unsigned AW           = $clog2(GCL_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gate_enable,
  input  logic                  cycle_start,
  input  logic [NUM_QUEUES-1:0] admin_gate_states,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [NUM_QUEUES-1:0] cfg_gate_states,
  input  logic [TI_WIDTH-1:0]   cfg_interval,
  input  logic [AW:0]           cfg_list_len,
  input  logic                  cfg_commit,
  output logic [NUM_QUEUES-1:0] oper_gate_states,
  output logic                  oper_bank,
  output logic                  commit_pending,
  output logic [AW-1:0]         entry_index,
  output logic                  cycle_overrun
);

  typedef enum logic [1:0] {StIdle, StWait, StRun, StHold} state_e;

  localparam logic [AW:0]       DepthLen = (AW+1)'(GCL_DEPTH);
  localparam logic [TI_WIDTH-1:0] Period = TI_WIDTH'(CLK_PERIOD_NS);

  logic [NUM_QUEUES-1:0] mem_gates [2][GCL_DEPTH];
  logic [TI_WIDTH-1:0]   mem_iv    [2][GCL_DEPTH];

  state_e                state_q, state_d;
  logic [NUM_QUEUES-1:0] gates_q, gates_d;
  logic                  bank_q, bank_d;
  logic                  pend_q, pend_d;
  logic [AW:0]           pend_len_q, pend_len_d;
  logic [AW:0]           len_q, len_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [TI_WIDTH-1:0]   rem_q, rem_d;
  logic                  ovr_q, ovr_d;

  logic                  start_bank;
  logic [AW:0]           start_len;
  logic [AW:0]           commit_len;
  logic [AW-1:0]         next_idx;
  logic                  is_last;
  logic                  take_start;

  // Admin bank is always the one not executing, even with a swap armed.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      mem_gates[~bank_q][cfg_addr] <= cfg_gate_states;
      mem_iv[~bank_q][cfg_addr]    <= cfg_interval;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gates_q    <= '1;
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_len_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gates_q    <= gates_d;
      bank_q     <= bank_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gates_d    = gates_q;
    bank_d     = bank_q;
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    ovr_d      = 1'b0;

    start_bank = pend_q ? ~bank_q : bank_q;
    start_len  = pend_q ? pend_len_q : len_q;
    commit_len = (cfg_list_len > DepthLen) ? DepthLen : cfg_list_len;
    next_idx   = idx_q + 1'b1;
    is_last    = ({1'b0, idx_q} == len_q - (AW+1)'(1));
    take_start = cycle_start && (state_q != StIdle);

    if (!gate_enable) begin
      state_d = StIdle;
      gates_d = admin_gate_states;
      idx_d   = '0;
    end else if (take_start) begin
      // A start in RUN truncates the list; it wins over a same-cycle expiry.
      ovr_d  = (state_q == StRun);
      bank_d = start_bank;
      len_d  = start_len;
      pend_d = 1'b0;
      idx_d  = '0;
      if (start_len == '0) begin
        state_d = StWait;
        gates_d = admin_gate_states;
      end else begin
        state_d = StRun;
        gates_d = mem_gates[start_bank][0];
        rem_d   = mem_iv[start_bank][0];
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWait;
          gates_d = admin_gate_states;
          idx_d   = '0;
        end
        StWait: gates_d = admin_gate_states;
        StRun: begin
          if (rem_q <= Period) begin
            if (is_last) begin
              state_d = StHold;
            end else begin
              idx_d   = next_idx;
              gates_d = mem_gates[bank_q][next_idx];
              rem_d   = mem_iv[bank_q][next_idx];
            end
          end else begin
            rem_d = rem_q - Period;
          end
        end
        StHold: ;
        default: state_d = StIdle;
      endcase
    end

    // Applied after the start handling so a coincident commit arms the following start.
    if (cfg_commit) begin
      pend_d     = 1'b1;
      pend_len_d = commit_len;
    end
  end

  always_comb begin
    oper_gate_states = gates_q;
    oper_bank        = bank_q;
    commit_pending   = pend_q;
    entry_index      = idx_q;
    cycle_overrun    = ovr_q;
  end

endmodule

// File: tb/tb_gcl_execute_sm.sv
// Self-checking bench for gcl_execute_sm: gate sequences are scoreboarded through a queue
// filled when each cycle start is driven.
module tb_gcl_execute_sm;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate_enable;
  logic        cycle_start;
  logic [7:0]  admin_gate_states;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_gate_states;
  logic [31:0] cfg_interval;
  logic [4:0]  cfg_list_len;
  logic        cfg_commit;
  logic [7:0]  oper_gate_states;
  logic        oper_bank;
  logic        commit_pending;
  logic [3:0]  entry_index;
  logic        cycle_overrun;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  exp_q[$];

  gcl_execute_sm #(
    .NUM_QUEUES   (8),
    .GCL_DEPTH    (16),
    .TI_WIDTH     (32),
    .CLK_PERIOD_NS(8)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .gate_enable      (gate_enable),
    .cycle_start      (cycle_start),
    .admin_gate_states(admin_gate_states),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_gate_states  (cfg_gate_states),
    .cfg_interval     (cfg_interval),
    .cfg_list_len     (cfg_list_len),
    .cfg_commit       (cfg_commit),
    .oper_gate_states (oper_gate_states),
    .oper_bank        (oper_bank),
    .commit_pending   (commit_pending),
    .entry_index      (entry_index),
    .cycle_overrun    (cycle_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] g, input logic [31:0] iv);
    cfg_we = 1'b1; cfg_addr = a; cfg_gate_states = g; cfg_interval = iv;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit(input logic [4:0] len);
    cfg_commit = 1'b1; cfg_list_len = len;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic start();
    cycle_start = 1'b1;
    tick();
    cycle_start = 1'b0;
  endtask

  task automatic push_n(input logic [7:0] g, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(g);
  endtask

  task automatic run_sb(input string tag);
    while (exp_q.size() > 0) begin
      check_eq(tag, oper_gate_states, exp_q.pop_front());
      tick();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      gate_enable = 1'($urandom); cycle_start = 1'($urandom);
      admin_gate_states = 8'($urandom); cfg_we = 1'($urandom); cfg_addr = 4'($urandom);
      cfg_gate_states = 8'($urandom); cfg_interval = $urandom; cfg_list_len = 5'($urandom);
      cfg_commit = 1'($urandom);
      tick();
    end
    check_eq("rst_gates", oper_gate_states, 8'hFF);
    check_eq("rst_bank", oper_bank, 0);
    check_eq("rst_pend", commit_pending, 0);
    check_eq("rst_idx", entry_index, 0);
    check_eq("rst_ovr", cycle_overrun, 0);
    gate_enable = 0; cycle_start = 0; admin_gate_states = 8'h33; cfg_we = 0;
    cfg_addr = 0; cfg_gate_states = 0; cfg_interval = 0; cfg_list_len = 0; cfg_commit = 0;
    tick();
    rst = 1'b0;

    // Basic list in bank 1
    wr(4'd0, 8'h01, 100);
    wr(4'd1, 8'h02, 16);
    wr(4'd2, 8'h80, 0);
    commit(5'd3);
    check_eq("commit_pend", commit_pending, 1);
    gate_enable = 1'b1;
    tick();
    check_eq("wait_admin", oper_gate_states, 8'h33);
    push_n(8'h01, 13); push_n(8'h02, 2); push_n(8'h80, 1); push_n(8'h80, 4);
    start();
    check_eq("basic_bank", oper_bank, 1);
    check_eq("basic_pend", commit_pending, 0);
    run_sb("basic_gates");
    check_eq("hold_idx", entry_index, 2);

    // Overruns: from HOLD (none), early in entry 0, in entry 1, on last-entry expiry
    start();
    check_eq("hold_start_ovr", cycle_overrun, 0);
    check_eq("hold_start_gates", oper_gate_states, 8'h01);
    ticks(4);
    start();
    check_eq("ovr0_pulse", cycle_overrun, 1);
    check_eq("ovr0_gates", oper_gate_states, 8'h01);
    check_eq("ovr0_idx", entry_index, 0);
    tick();
    check_eq("ovr0_clear", cycle_overrun, 0);
    ticks(12);
    check_eq("e1_gates", oper_gate_states, 8'h02);
    check_eq("e1_idx", entry_index, 1);
    start();
    check_eq("ovr1_pulse", cycle_overrun, 1);
    check_eq("ovr1_gates", oper_gate_states, 8'h01);
    check_eq("ovr1_idx", entry_index, 0);
    ticks(15);
    check_eq("e2_gates", oper_gate_states, 8'h80);
    check_eq("e2_idx", entry_index, 2);
    start();
    check_eq("ovr2_pulse", cycle_overrun, 1);
    check_eq("ovr2_gates", oper_gate_states, 8'h01);

    // Commit coincident with start: swap only at the following start
    wr(4'd0, 8'h11, 800);
    cfg_commit = 1'b1; cfg_list_len = 5'd1; cycle_start = 1'b1;
    tick();
    cfg_commit = 1'b0; cycle_start = 1'b0;
    check_eq("coin_bank", oper_bank, 1);
    check_eq("coin_pend", commit_pending, 1);
    check_eq("coin_gates", oper_gate_states, 8'h01);
    tick();
    start();
    check_eq("coin2_bank", oper_bank, 0);
    check_eq("coin2_pend", commit_pending, 0);
    check_eq("coin2_gates", oper_gate_states, 8'h11);

    // Disable during entry 1 with a commit pending
    commit(5'd3);
    start();
    check_eq("dis_bank", oper_bank, 1);
    commit(5'd2);
    ticks(12);
    check_eq("dis_e1", oper_gate_states, 8'h02);
    admin_gate_states = 8'h5A; gate_enable = 1'b0;
    tick();
    check_eq("dis_gates", oper_gate_states, 8'h5A);
    check_eq("dis_idx", entry_index, 0);
    check_eq("dis_pend", commit_pending, 1);
    start();
    check_eq("idle_start_bank", oper_bank, 1);
    check_eq("idle_start_pend", commit_pending, 1);
    check_eq("idle_start_gates", oper_gate_states, 8'h5A);

    // Length 0: re-latched while pending, then WAIT tracking admin
    commit(5'd0);
    gate_enable = 1'b1;
    tick();
    start();
    check_eq("len0_bank", oper_bank, 0);
    check_eq("len0_pend", commit_pending, 0);
    check_eq("len0_gates", oper_gate_states, 8'h5A);
    admin_gate_states = 8'hC3;
    tick();
    check_eq("len0_track1", oper_gate_states, 8'hC3);
    admin_gate_states = 8'h3C;
    tick();
    check_eq("len0_track2", oper_gate_states, 8'h3C);
    check_eq("len0_idx", entry_index, 0);

    // Length 20 clamps to 16; entry 0 interval 9 spans 2 cycles, the rest exactly 1
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 13 + 7), (i == 0) ? 32'd9 : ((i % 2) ? 32'd3 : 32'd8));
    commit(5'd20);
    for (int i = 0; i < 16; i++) push_n(8'(i * 13 + 7), (i == 0) ? 2 : 1);
    push_n(8'(15 * 13 + 7), 3);
    start();
    check_eq("len20_bank", oper_bank, 1);
    run_sb("len20_gates");
    check_eq("len20_idx", entry_index, 15);

    // Reset mid-RUN with a commit armed
    commit(5'd5);
    start();
    check_eq("mid_gates", oper_gate_states, 8'h11);
    commit(5'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_gates", oper_gate_states, 8'hFF);
    check_eq("mrst_bank", oper_bank, 0);
    check_eq("mrst_pend", commit_pending, 0);
    check_eq("mrst_idx", entry_index, 0);
    tick();
    start();
    check_eq("mrst_start_bank", oper_bank, 0);
    check_eq("mrst_start_gates", oper_gate_states, 8'h3C);
    check_eq("mrst_start_ovr", cycle_overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
